// File: rtl/dsp_div_pkg.sv
// rtl/dsp_div_pkg.sv - shared types and elaboration helpers for the fabric divider
package dsp_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_e;

  // Bits needed to count down from n-1 to 0.
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit widths_ok(input int divisor_w, input int quotient_w, input int dividend_w);
    return dividend_w == divisor_w + quotient_w;
  endfunction

endpackage

// File: rtl/dsp_div_step.sv
// rtl/dsp_div_step.sv - one combinational restoring-division step
module dsp_div_step #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH:0]   r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0]   s;
  logic [WIDTH+1:0] t;

  always_comb begin
    s = {r[WIDTH-1:0], bit_in};
    t = {1'b0, s} - {2'b00, divisor};
    // A set r msb means the shifted value already exceeds any divisor.
    q_bit = r[WIDTH] | ~t[WIDTH+1];
    r_next = q_bit ? t[WIDTH:0] : s;
  end

endmodule

// File: rtl/dsp_54by27u_div.sv
// rtl/dsp_54by27u_div.sv - sequential unsigned 54/27 restoring divider, one quotient bit per clock
module dsp_54by27u_div
  import dsp_div_pkg::*;
#(
  parameter int DIVISOR_WIDTH  = 27,
  parameter int QUOTIENT_WIDTH = 27,
  parameter int DIVIDEND_WIDTH = 54
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int CW = count_width(QUOTIENT_WIDTH);

  if (!widths_ok(DIVISOR_WIDTH, QUOTIENT_WIDTH, DIVIDEND_WIDTH)) begin : g_width_check
    $fatal(1, "dsp_54by27u_div: DIVIDEND_WIDTH must equal DIVISOR_WIDTH+QUOTIENT_WIDTH");
  end

  div_state_e state, state_next;

  logic [DIVISOR_WIDTH:0]    r_q;
  logic [QUOTIENT_WIDTH-1:0] q_q;
  logic [DIVISOR_WIDTH-1:0]  div_q;
  logic [CW-1:0]             cnt;

  logic [DIVISOR_WIDTH-1:0]  dividend_hi;
  logic                      accept;
  logic                      is_zero;
  logic                      is_ovf;
  logic [DIVISOR_WIDTH:0]    r_next;
  logic                      q_bit;
  logic [QUOTIENT_WIDTH-1:0] q_next;

  assign dividend_hi = dividend[DIVIDEND_WIDTH-1:QUOTIENT_WIDTH];
  assign is_zero     = (divisor == '0);
  assign is_ovf      = !is_zero && (dividend_hi >= divisor);
  assign q_next      = {q_q[QUOTIENT_WIDTH-2:0], q_bit};

  dsp_div_step #(
    .WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .r      (r_q),
    .bit_in (q_q[QUOTIENT_WIDTH-1]),
    .divisor(div_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    out_valid  = (state == DONE);
    accept     = in_valid & in_ready;
    case (state)
      IDLE: if (accept) state_next = (is_zero || is_ovf) ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_next = (is_zero || is_ovf) ? DONE : RUN;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers are separate from the working R/Q so outputs only move when a result lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      if (is_zero || is_ovf) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= is_zero;
        overflow    <= is_ovf;
      end else begin
        r_q   <= {1'b0, dividend_hi};
        q_q   <= dividend[QUOTIENT_WIDTH-1:0];
        div_q <= divisor;
        cnt   <= CW'(QUOTIENT_WIDTH - 1);
      end
    end else if (state == RUN) begin
      r_q <= r_next;
      q_q <= q_next;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        quotient    <= q_next;
        remainder   <= r_next[DIVISOR_WIDTH-1:0];
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_54by27u_div.sv
// tb/tb_dsp_54by27u_div.sv - directed and randomized checks for dsp_54by27u_div
module tb_dsp_54by27u_div;

  localparam logic [26:0] ONES = 27'h7FFFFFF;
  localparam int N_RAND = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [53:0] dividend = '0;
  logic [26:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [26:0] quotient;
  logic [26:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dsp_54by27u_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic do_op(input logic [53:0] dd, input logic [26:0] dv, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    dividend = dd; divisor = dv; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    while (!in_ready && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if ({quotient, remainder, div_by_zero, overflow} !== 56'd0) begin miscompares++; $display("FAIL reset_outputs got q=%h r=%h z=%b o=%b want 0", quotient, remainder, div_by_zero, overflow); end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(54'd1000, 27'd7, lat);
    vectors++; if (lat !== 27) begin miscompares++; $display("FAIL basic_latency got %0d want 27", lat); end
    vectors++; if (quotient !== 27'd142) begin miscompares++; $display("FAIL basic_quotient got %0d want 142", quotient); end
    vectors++; if (remainder !== 27'd6) begin miscompares++; $display("FAIL basic_remainder got %0d want 6", remainder); end
    vectors++; if ({div_by_zero, overflow} !== 2'b00) begin miscompares++; $display("FAIL basic_flags got %b%b want 00", div_by_zero, overflow); end
    drain();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_max();
    int lat;
    do_op(54'h3F_FFFF_F7FF_FFFF, 27'h7FFFFFF, lat);
    vectors++; if (lat !== 27) begin miscompares++; $display("FAIL max_latency got %0d want 27", lat); end
    vectors++; if (quotient !== 27'h7FFFFFF) begin miscompares++; $display("FAIL max_quotient got %h want 7ffffff", quotient); end
    vectors++; if (remainder !== 27'h7FFFFFE) begin miscompares++; $display("FAIL max_remainder got %h want 7fffffe", remainder); end
    drain();
  endtask

  task automatic test_zero_overflow();
    int lat;
    do_op(54'd5, 27'd0, lat);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL zero_latency got %0d want 0", lat); end
    vectors++; if ({div_by_zero, overflow} !== 2'b10) begin miscompares++; $display("FAIL zero_flags got %b%b want 10", div_by_zero, overflow); end
    vectors++; if (quotient !== ONES || remainder !== 27'd0) begin miscompares++; $display("FAIL zero_result got q=%h r=%h want 7ffffff/0", quotient, remainder); end
    drain();
    do_op(54'd3 << 27, 27'd3, lat);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL ovf_latency got %0d want 0", lat); end
    vectors++; if ({div_by_zero, overflow} !== 2'b01) begin miscompares++; $display("FAIL ovf_flags got %b%b want 01", div_by_zero, overflow); end
    vectors++; if (quotient !== ONES || remainder !== 27'd0) begin miscompares++; $display("FAIL ovf_result got q=%h r=%h want 7ffffff/0", quotient, remainder); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(54'd1000, 27'd7, lat);
    @(negedge clk); dividend = 54'd20; divisor = 27'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold cycle %0d got v=%b rdy=%b want 1/0", i, out_valid, in_ready); end
      vectors++; if (quotient !== 27'd142 || remainder !== 27'd6) begin miscompares++; $display("FAIL bp_stable cycle %0d got q=%0d r=%0d want 142/6", i, quotient, remainder); end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_overlap_valid got %b want 0", out_valid); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++; if (lat !== 27) begin miscompares++; $display("FAIL bp_latency got %0d want 27", lat); end
    vectors++; if (quotient !== 27'd6 || remainder !== 27'd2) begin miscompares++; $display("FAIL bp_result got q=%0d r=%0d want 6/2", quotient, remainder); end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk); dividend = 54'd12345; divisor = 27'd10; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_run_hs got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    vectors++; if ({quotient, remainder, div_by_zero, overflow} !== 56'd0) begin miscompares++; $display("FAIL rst_run_outputs got q=%h r=%h want 0", quotient, remainder); end
    @(negedge clk); rst_n = 1'b1;
    do_op(54'd1000, 27'd7, lat);
    vectors++; if (lat !== 27) begin miscompares++; $display("FAIL rst_run_latency got %0d want 27", lat); end
    vectors++; if (quotient !== 27'd142 || remainder !== 27'd6) begin miscompares++; $display("FAIL rst_run_result got q=%0d r=%0d want 142/6", quotient, remainder); end
    drain();
  endtask

  task automatic test_random();
    logic [26:0] qa[$];
    logic [26:0] qr[$];
    logic [26:0] a, b, r, ea, er;
    int sent, got, cyc;
    bit pend;
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    a = '0; b = 27'd1; r = '0;
    while (got < N_RAND && cyc < 40000) begin
      @(negedge clk);
      if (!pend && sent < N_RAND && ($urandom % 4) != 0) begin
        a = 27'($urandom);
        b = (($urandom % 2) == 0) ? 27'($urandom_range(1, 255)) : 27'($urandom);
        if (b == 27'd0) b = 27'd1;
        r = 27'($urandom % {5'd0, b});
        dividend = 54'(a) * 54'(b) + 54'(r);
        divisor = b;
        pend = 1'b1;
      end
      in_valid = pend;
      out_ready = (($urandom % 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got++;
        if (qa.size() == 0) begin
          vectors++; miscompares++; $display("FAIL rand_extra result q=%h with nothing expected", quotient);
        end else begin
          ea = qa.pop_front(); er = qr.pop_front();
          vectors++; if (quotient !== ea) begin miscompares++; $display("FAIL rand_quotient #%0d got %h want %h", got, quotient, ea); end
          vectors++; if (remainder !== er || div_by_zero || overflow) begin miscompares++; $display("FAIL rand_remainder #%0d got %h z=%b o=%b want %h", got, remainder, div_by_zero, overflow, er); end
        end
      end
      if (in_valid && in_ready) begin
        qa.push_back(a); qr.push_back(r); pend = 1'b0; sent++;
      end
      cyc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (got !== N_RAND || qa.size() != 0) begin miscompares++; $display("FAIL rand_count got %0d results (%0d pending) want %0d", got, qa.size(), N_RAND); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
